bcd_to_bin_seq: RTL

- Sequential BCD-to-binary decoder: the inverse of the binary-to-BCD conversion on the CORDIC display path.
- Converts a packed 12-digit BCD word (front-panel or host-entered value) into a binary integer.
- Typical use: turns operator-entered BCD angles or magnitudes back into binary before they reach the phase-step multiplier and CORDIC core.
- Uses reverse double-dabble (shift right, then subtract 3 from any digit that is 8 or more), one bit per clock, with a start/busy/done handshake.

---
 rtl/cordic_pkg.sv | 21 ++
 rtl/bcd_digit_adj.sv | 9 +
 rtl/bcd_to_bin_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, FSM state type and sizing helper for the BCD-to-binary decoder.
package cordic_pkg;

  localparam int DIGITS_DEF = 12;
  localparam int BIN_W_DEF  = 40;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Bits needed to hold values 0 .. n-1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of reverse double-dabble: d >= 8 becomes d-3.
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd8) ? d - 4'd3 : d;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary decoder (reverse double-dabble, one bit per clock).
// Optional macro BCD_CHECK_EN rejects nibbles above 9 with err and an early done.
module bcd_to_bin_seq
  import cordic_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    bin_out,
  output logic                err
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int SREG_W = BCD_W + BIN_W;
  localparam int CNT_W  = clog2(BIN_W + 1);

  state_t            state, state_nx;
  logic [SREG_W-1:0] sreg, sreg_nx;
  logic [SREG_W-1:0] shifted, adjusted;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              busy_nx, done_nx;
  logic [BIN_W-1:0]  bin_nx;
  logic              start_ok;
  logic              bad_q;

  // Start is honoured in IDLE and in FINISH, which gives back-to-back conversions.
  assign start_ok = start && ((state == IDLE) || (state == FINISH));

  assign shifted = {1'b0, sreg[SREG_W-1:1]};
  assign adjusted[BIN_W-1:0] = shifted[BIN_W-1:0];

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .d(shifted[BIN_W + 4*i +: 4]),
      .q(adjusted[BIN_W + 4*i +: 4])
    );
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_nx = state;
    sreg_nx  = sreg;
    cnt_nx   = cnt;
    busy_nx  = busy;
    done_nx  = 1'b0;
    bin_nx   = bin_out;
    case (state)
      IDLE, FINISH: begin
        if (start_ok) begin
          sreg_nx  = {bcd_in, {BIN_W{1'b0}}};
          cnt_nx   = '0;
          busy_nx  = 1'b1;
          state_nx = SHIFT;
        end else begin
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      SHIFT: begin
        if (bad_q) begin
          bin_nx   = '0;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = FINISH;
        end else begin
          sreg_nx = adjusted;
          cnt_nx  = cnt + 1'b1;
          if (cnt == CNT_W'(BIN_W - 1)) begin
            bin_nx   = adjusted[BIN_W-1:0];
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = FINISH;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the shift register is cleared too so the post-reset state is fully defined, not just the control bits.
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the pre-edge values from the comb block.
      state   <= state_nx;
      sreg    <= sreg_nx;
      cnt     <= cnt_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      bin_out <= bin_nx;
    end
  end

`ifdef BCD_CHECK_EN
  logic bcd_bad;

  always_comb begin
    bcd_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_in[4*i +: 4] > 4'd9) bcd_bad = 1'b1;
  end

  // bad_q diverts the first SHIFT cycle into an immediate zero result with err.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bad_q <= 1'b0;
      err   <= 1'b0;
    end else if (start_ok) begin
      bad_q <= bcd_bad;
      err   <= 1'b0;
    end else if ((state == SHIFT) && bad_q) begin
      err   <= 1'b1;
    end
  end
`else
  assign bad_q = 1'b0;
  assign err   = 1'b0;
`endif

endmodule
